// File: rtl/jt12_mmr_wr.sv
// YM2612 register write stage: sequences address/data writes, owns globals 0x24-0x28 and
// forwards channel/operator writes. Optional data-write counter under JT12_MMR_WRCNT_EN.
module jt12_mmr_wr #(
  parameter int unsigned ADDR_BUSY = 1,
  parameter int unsigned DATA_BUSY = 8
) (
  input  logic        rst_aux,
  input  logic        clk,
  input  logic        clk_fm_en,
  input  logic        write,
  input  logic [1:0]  addr_s,
  input  logic [7:0]  din_s,
  output logic        busy_mmr,
  output logic        reg_wr,
  output logic        reg_part,
  output logic [7:0]  reg_addr,
  output logic [7:0]  reg_data,
  output logic [9:0]  value_A,
  output logic [7:0]  value_B,
  output logic        load_A,
  output logic        load_B,
  output logic        en_irq_A,
  output logic        en_irq_B,
  output logic        clr_flag_A,
  output logic        clr_flag_B,
  output logic [1:0]  ch3_mode,
  output logic        kon,
  output logic [3:0]  kon_op,
  output logic [2:0]  kon_ch,
  output logic [15:0] wr_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [4:0] ADDR_CNT = 5'(ADDR_BUSY);
  localparam logic [4:0] DATA_CNT = 5'(DATA_BUSY);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        write_l_q;
  logic        armed_q;
  logic [7:0]  sel_addr_q;
  logic        sel_part_q;
  logic        accept, acc_addr, acc_data;
  logic        hit_glob, hit_chan;

  // armed_q blocks a write level held through reset from counting as a fresh edge
  assign accept   = clk_fm_en & write & ~write_l_q & armed_q & (state_q == IDLE);
  assign acc_addr = accept & ~addr_s[0];
  assign acc_data = accept &  addr_s[0];
  assign hit_glob = ~sel_part_q & (sel_addr_q >= 8'h24) & (sel_addr_q <= 8'h28);
  assign hit_chan = sel_addr_q >= 8'h30;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clk_fm_en) begin
      case (state_q)
        IDLE: if (accept) begin
          state_d = BUSY;
          cnt_d   = addr_s[0] ? DATA_CNT : ADDR_CNT;
        end
        BUSY: if (cnt_q == 5'd1) state_d = IDLE;
              else               cnt_d   = cnt_q - 5'd1;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_aux) begin
    if (rst_aux) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      write_l_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (clk_fm_en) begin
        write_l_q <= write;
        if (!write) armed_q <= 1'b1;
      end
    end
  end

  assign busy_mmr = (state_q == BUSY);

  always_ff @(posedge clk or posedge rst_aux) begin
    if (rst_aux) begin
      sel_addr_q <= '0;
      sel_part_q <= 1'b0;
      reg_wr     <= 1'b0;
      reg_part   <= 1'b0;
      reg_addr   <= '0;
      reg_data   <= '0;
      value_A    <= '0;
      value_B    <= '0;
      load_A     <= 1'b0;
      load_B     <= 1'b0;
      en_irq_A   <= 1'b0;
      en_irq_B   <= 1'b0;
      clr_flag_A <= 1'b0;
      clr_flag_B <= 1'b0;
      ch3_mode   <= '0;
      kon        <= 1'b0;
      kon_op     <= '0;
      kon_ch     <= '0;
    end else begin
      reg_wr     <= acc_data & hit_chan;
      kon        <= acc_data & hit_glob & (sel_addr_q == 8'h28);
      clr_flag_A <= acc_data & hit_glob & (sel_addr_q == 8'h27) & din_s[4];
      clr_flag_B <= acc_data & hit_glob & (sel_addr_q == 8'h27) & din_s[5];
      if (acc_addr) begin
        sel_addr_q <= din_s;
        sel_part_q <= addr_s[1];
      end
      if (acc_data && hit_chan) begin
        reg_part <= sel_part_q;
        reg_addr <= sel_addr_q;
        reg_data <= din_s;
      end
      if (acc_data && hit_glob) begin
        case (sel_addr_q)
          8'h24: value_A[9:2] <= din_s;
          8'h25: value_A[1:0] <= din_s[1:0];
          8'h26: value_B      <= din_s;
          8'h27: begin
            load_A   <= din_s[0];
            load_B   <= din_s[1];
            en_irq_A <= din_s[2];
            en_irq_B <= din_s[3];
            ch3_mode <= din_s[7:6];
          end
          8'h28: begin
            kon_op <= din_s[7:4];
            kon_ch <= din_s[2:0];
          end
          default: ;
        endcase
      end
    end
  end

`ifdef JT12_MMR_WRCNT_EN
  logic [15:0] wr_cnt_q;
  always_ff @(posedge clk or posedge rst_aux) begin
    if (rst_aux)       wr_cnt_q <= '0;
    else if (acc_data) wr_cnt_q <= wr_cnt_q + 16'd1;
  end
  assign wr_cnt = wr_cnt_q;
`else
  assign wr_cnt = '0;
`endif

endmodule
